// File: rtl/grid_port_arbiter.sv
// grid_port_arbiter: shares the single grid BRAM port between particle push
// gather (0), charge scatter (1) and field solver (2). Eligibility follows the
// current simulation step; read responses are routed back through a tag
// pipeline, and outstanding reads are drained on every step change.
// Optional build macro GRID_ARB_STATS_EN adds the stall_cnt / drain_cnt outputs.

package grid_port_arbiter_pkg;
    typedef enum logic {
        SCATTER = 1'b0,
        SOLVE   = 1'b1
    } step_t;
endpackage

module grid_port_arbiter
    import grid_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  step_t                  step,
    input  logic [2:0]             req_valid,
    output logic [2:0]             req_ready,
    input  logic [2:0]             req_we,
    input  logic [2:0][ADDR_W-1:0] req_addr,
    input  logic [2:0][DATA_W-1:0] req_wdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [2:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   idle
`ifdef GRID_ARB_STATS_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [15:0]            drain_cnt
`endif
);

    localparam int CNT_W = $clog2(RD_LAT + 2);

    typedef enum logic {
        ARB   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    step_t                step_q;
    logic                 rr_q;      // last push/scatter grant: 0 push, 1 scatter
    logic [2:0]           hs;
    logic                 gnt;
    logic                 gnt_rd;
    logic [1:0]           gnt_id;
    logic [RD_LAT:0]      tag_v;     // entry k lines up with mem_en + k cycles
    logic [RD_LAT:0][1:0] tag_id;
    logic [CNT_W-1:0]     inflight;

    assign hs     = req_valid & req_ready;
    assign gnt    = |hs;
    assign gnt_id = hs[2] ? 2'd2 : (hs[1] ? 2'd1 : 2'd0);
    assign gnt_rd = gnt & ~req_we[gnt_id];

    assign idle = (state_q == ARB) & ~mem_en & (inflight == '0) & ~|req_valid;

    // Next-state and grant decision; grants use the registered step copy
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            ARB: begin
                if (step != step_q) state_d = DRAIN;
                if (step_q == SCATTER) begin
                    req_ready[0] = req_valid[0] & (~req_valid[1] | rr_q);
                    req_ready[1] = req_valid[1] & (~req_valid[0] | ~rr_q);
                end else begin
                    req_ready[2] = req_valid[2];
                end
            end
            DRAIN: begin
                if (inflight == '0 && !mem_en) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    // State register, step copy and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            step_q  <= SCATTER;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            step_q  <= step;
            if (hs[0]) rr_q <= 1'b0;
            else if (hs[1]) rr_q <= 1'b1;
        end
    end

    // Register the granted request onto the memory port for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= gnt;
            mem_we <= gnt & req_we[gnt_id];
            if (gnt) begin
                mem_addr  <= req_addr[gnt_id];
                mem_wdata <= req_wdata[gnt_id];
            end
        end
    end

    // Tag pipeline, response routing and in-flight read count
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v     <= '0;
            tag_id    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            inflight  <= '0;
        end else begin
            tag_v     <= {tag_v[RD_LAT-1:0], gnt_rd};
            tag_id    <= {tag_id[RD_LAT-1:0], gnt_id};
            rsp_valid <= tag_v[RD_LAT] ? (3'b001 << tag_id[RD_LAT]) : 3'b000;
            if (tag_v[RD_LAT]) rsp_data <= mem_rdata;
            case ({gnt_rd, tag_v[RD_LAT]})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef GRID_ARB_STATS_EN
    // Saturating counters of stalled-request cycles and drain cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            if (|req_valid && req_ready == 3'b000 && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (state_q == DRAIN && drain_cnt != '1)
                drain_cnt <= drain_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/grid_port_arbiter.md
# grid_port_arbiter

- Arbitrates the single grid-memory port among three requesters: particle push gather (0), charge scatter (1) and field solver (2).
- Eligibility is set by the current simulation step: in SCATTER, push and scatter share the port round-robin; in SOLVE, only the solver is served.
- Tracks in-flight reads with a tag pipeline so each read response is routed back to the requester that issued it.
- Sits between the top-level step controller and the grid BRAM.
- Drains outstanding reads on every step change, so the controller can switch phases safely using `idle`.

## Interface
Parameters:
- ADDR_W, 12, grid memory address width
- DATA_W, 32, grid word width
- RD_LAT, 2, memory read latency in cycles from mem_en to mem_rdata valid (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- step  in  step_t  current phase (SCATTER/SOLVE) from the step controller
- req_valid  in  3  per-requester request valid (bit 0 push, bit 1 scatter, bit 2 solve)
- req_ready  out  3  per-requester accept; handshake = valid & ready
- req_we  in  3  per-requester write enable (0 = read)
- req_addr  in  3×ADDR_W  per-requester address, packed [2:0]
- req_wdata  in  3×DATA_W  per-requester write data, packed [2:0]
- mem_en, mem_we  out  1  memory port enable / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- rsp_valid  out  3  one-hot read response valid
- rsp_data  out  DATA_W  read response data, shared by all requesters
- idle  out  1  no request pending in the port and no read in flight

## Operation
- FSM states: ARB and DRAIN.
- ARB → DRAIN when `step` differs from its registered copy `step_q`; `step_q` is updated on every cycle.
- DRAIN → ARB when the in-flight read count is 0 and mem_en is low. In DRAIN, req_ready = 0.
- req_ready is combinational from req_valid, the state, step_q and the round-robin pointer `rr`. At most one bit of req_ready is high per cycle.
- ARB with step_q = SCATTER:
  - Solver is never ready.
  - If only one of push/scatter is valid, that one is granted.
  - If both are valid, the one not granted last is served; `rr` records the last granted requester.
  - Reset value of `rr` favours push.
- ARB with step_q = SOLVE: only the solver may be granted; push and scatter are held off.
- On a handshake, the request is registered onto the mem_* outputs for exactly one cycle. A read also pushes the requester id into a tag shift register of depth RD_LAT+1.
- Response: rsp_valid[id] and rsp_data = mem_rdata are registered one cycle after mem_rdata becomes valid.
- Writes produce no response.
- An in-flight read counter of width clog2(RD_LAT+2) increments on a read handshake and decrements on response. Increment and decrement in the same cycle leave it unchanged.
- idle = (state == ARB) & ~mem_en & (inflight == 0) & ~|req_valid.
- Reset values:
  - req_ready = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rsp_valid = 0, rsp_data = 0, idle = 1 (after first clock).
  - state = ARB, step_q = SCATTER, rr = scatter (so push wins first), tag pipe cleared, inflight = 0.
- Reset mid-operation drops all in-flight reads; no rsp_valid is emitted for them.

## Timing
- Handshake in cycle N → mem_en in cycle N+1 → mem_rdata in cycle N+1+RD_LAT → rsp_valid in cycle N+2+RD_LAT.
- Throughput: one access per cycle, back-to-back, including alternating push/scatter grants.
- A step change in cycle N makes req_ready 0 from cycle N+1. Granting resumes the cycle after the last in-flight response.
- A step change while a request is pending with no read in flight costs one DRAIN cycle.
- Responses keep issue order; there is no reordering.

## Configuration
- GRID_ARB_STATS_EN defined:
  - Adds output `stall_cnt` [31:0], a saturating count of cycles in which any req_valid bit is high but no bit of req_ready is high.
  - Adds output `drain_cnt` [15:0], a saturating count of cycles spent in DRAIN.
  - Both counters are cleared by rst.
- Undefined: both ports and counters are absent; functional behaviour is identical.

## Test plan
- Push reads addr 0x010 at N with RD_LAT=2 → mem_en/addr 0x010 at N+1; rsp_valid = 3'b001 with mem_rdata at N+4.
- Push and scatter both valid continuously for 6 cycles in SCATTER → grants alternate push, scatter, push, scatter, push, scatter; no idle cycles on mem_en.
- Solver valid during SCATTER → req_ready[2] = 0 for the whole phase. Step switches to SOLVE → solver granted once the drain completes.
- Three push reads issued back-to-back, then step changes → req_ready stays 0 until the third rsp_valid; idle = 1 the cycle after it, with no request pending.
- rst asserted with two reads in flight → no rsp_valid afterwards; all outputs at reset values; idle = 1.
- GRID_ARB_STATS_EN: push valid during SOLVE for 5 cycles → stall_cnt = 5.
